// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared definitions for the control-bundle pipeline.
//   W_DEFAULT  - default control-bundle width in bits
//   STAGES_MAX - largest supported number of register stages
//   occW()     - width of the occupancy counter for a given stage count
package ctrl_pipe_pkg;

  localparam int W_DEFAULT  = 45;
  localparam int STAGES_MAX = 8;

  // Enough bits to count from 0 up to and including 'stages'.
  function automatic int occW(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/ctrl_pipe_n_if.sv
// ctrl_pipe_n_if: signal bundle between the decode side / pipeline controller
// and the control-bundle pipeline.
//   in_valid, in_data   - decode-side bundle offered to stage 0
//   in_ready            - stage 0 accepts this cycle
//   stall_req/flush_req - per-stage hold / squash requests
//   stage_valid/_data   - per-stage contents (stage i at [i*W +: W])
//   out_valid/out_data  - copy of the oldest stage
//   occupancy           - number of valid stages
// master: the side driving bundles and requests; slave: the pipeline.
interface ctrl_pipe_n_if
  import ctrl_pipe_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int STAGES = 3
);

  localparam int OCC_W = occW(STAGES);

  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic [STAGES-1:0]     stall_req;
  logic [STAGES-1:0]     flush_req;
  logic [STAGES-1:0]     stage_valid;
  logic [STAGES*W-1:0]   stage_data;
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, in_data, stall_req, flush_req,
    input  in_ready, stage_valid, stage_data, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush_req,
    output in_ready, stage_valid, stage_data, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one valid+data register of the control pipeline.
//   clk, rst    - clock, synchronous active-low reset
//   kill        - squash: valid and data cleared next cycle (beats hold)
//   hold        - keep current contents
//   loadValid/loadData - value loaded when neither kill nor hold
//   validQ/dataQ - registered contents; data is all-zero whenever invalid
//   validNext   - combinational next-state valid, used for occupancy
module ctrl_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kill,
  input  logic         hold,
  input  logic         loadValid,
  input  logic [W-1:0] loadData,
  output logic         validQ,
  output logic [W-1:0] dataQ,
  output logic         validNext
);

  always_comb begin
    validNext = loadValid;
    if (kill)
      validNext = 1'b0;
    else if (hold)
      validNext = validQ;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      validQ <= 1'b0;
      dataQ  <= '0;
    end else if (kill) begin
      validQ <= 1'b0;
      dataQ  <= '0;
    end else if (!hold) begin
      validQ <= loadValid;
      // An empty slot always carries zero so downstream control is inert.
      dataQ  <= loadValid ? loadData : '0;
    end
  end

endmodule

// File: rtl/ctrl_pipe_n.sv
// ctrl_pipe_n: STAGES-deep control-bundle pipeline with per-stage stall and
// flush. Stage 0 is youngest, STAGES-1 oldest.
//   clk - clock, all state on rising edge
//   rst - synchronous active-low reset
//   bus - ctrl_pipe_n_if slave port (bundle in, requests in, stage view out)
// An older stall holds every younger stage; an older flush squashes every
// younger stage. A flush wins over a stall on any stage.
module ctrl_pipe_n
  import ctrl_pipe_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int STAGES = 3
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_pipe_n_if.slave   bus
);

  localparam int OCC_W = occW(STAGES);

  logic [STAGES-1:0] stallEff;
  logic [STAGES-1:0] holdEff;
  logic [STAGES-1:0] killEff;
  logic [STAGES-1:0] loadValid;
  logic [STAGES-1:0] validQ;
  logic [STAGES-1:0] validNext;
  logic [W-1:0]      loadData [STAGES];
  logic [W-1:0]      dataQ    [STAGES];
  logic [OCC_W-1:0]  occQ;

  function automatic logic [OCC_W-1:0] popCount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++)
      cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // A stall on a stage that is flushed in the same cycle is dropped, so it
  // neither holds younger stages nor blocks the input.
  always_comb begin
    stallEff = bus.stall_req & ~bus.flush_req;
    holdEff  = '0;
    killEff  = '0;
    for (int i = 0; i < STAGES; i++) begin
      holdEff[i] = |(stallEff      >> i);
      killEff[i] = |(bus.flush_req >> i);
    end
  end

  // Stage i>0 takes a bubble when the stage behind it is held.
  always_comb begin
    loadValid[0] = bus.in_valid;
    loadData[0]  = bus.in_data;
    for (int i = 1; i < STAGES; i++) begin
      loadValid[i] = validQ[i-1] & ~holdEff[i-1];
      loadData[i]  = holdEff[i-1] ? '0 : dataQ[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    ctrl_pipe_stage #(.W(W)) uStage (
      .clk       (clk),
      .rst       (rst),
      .kill      (killEff[g]),
      .hold      (holdEff[g]),
      .loadValid (loadValid[g]),
      .loadData  (loadData[g]),
      .validQ    (validQ[g]),
      .dataQ     (dataQ[g]),
      .validNext (validNext[g])
    );
  end

  // Occupancy is registered from the same next-state that feeds the stages,
  // so it always agrees with stage_valid.
  always_ff @(posedge clk) begin
    if (!rst)
      occQ <= '0;
    else
      occQ <= popCount(validNext);
  end

  always_comb begin
    bus.stage_data = '0;
    for (int i = 0; i < STAGES; i++)
      bus.stage_data[i*W +: W] = dataQ[i];
  end

  assign bus.in_ready    = ~holdEff[0];
  assign bus.stage_valid = validQ;
  assign bus.out_valid   = validQ[STAGES-1];
  assign bus.out_data    = dataQ[STAGES-1];
  assign bus.occupancy   = occQ;

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// tb_ctrl_pipe_n: scoreboard bench for ctrl_pipe_n with W=8, STAGES=3.
// Expected out_data values are queued as bundles are issued; a monitor pops
// one per bundle leaving the oldest stage. Directed state checks run inline.
module tb_ctrl_pipe_n;

  localparam int W      = 8;
  localparam int STAGES = 3;

  logic clk;
  logic rst;

  ctrl_pipe_n_if #(.W(W), .STAGES(STAGES)) bus ();

  ctrl_pipe_n #(.W(W), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sbq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit expectOut);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (expectOut) sbq.push_back(d);
    tick();
  endtask

  // A bundle leaves the oldest stage at the next edge when it is valid and
  // neither held nor flushed there.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 &&
        bus.stall_req[STAGES-1] === 1'b0 && bus.flush_req[STAGES-1] === 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected no output at %0t", bus.out_data, $time);
      end else begin
        check("sb_out_data", 64'(bus.out_data), 64'(sbq.pop_front()));
      end
    end
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall_req = '0;
    bus.flush_req = '0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 64'(bus.stage_valid), 64'h0);
    check("rst_data",  64'(bus.stage_data),  64'h0);
    check("rst_occ",   64'(bus.occupancy),   64'h0);
    check("rst_out",   64'(bus.out_valid),   64'h0);
    check("rst_ready", 64'(bus.in_ready),    64'h1);
    rst = 1'b1;

    // Streaming 0x11, 0x22, 0x33
    send(8'h11, 1'b1);
    check("s1_valid", 64'(bus.stage_valid), 64'h1);
    check("s1_data",  64'(bus.stage_data),  64'h000011);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("s3_valid", 64'(bus.stage_valid), 64'h7);
    check("s3_data",  64'(bus.stage_data),  64'h112233);
    check("s3_occ",   64'(bus.occupancy),   64'h3);
    tick();
    check("s4_occ",   64'(bus.occupancy),   64'h2);
    repeat (3) tick();
    check("s_drained", 64'(bus.occupancy),  64'h0);

    // Stall on stage 1 with a full pipe
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    bus.stall_req = 3'b010;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h44;
    #1;
    check("st_ready0", 64'(bus.in_ready), 64'h0);
    tick();
    check("st1_valid", 64'(bus.stage_valid), 64'h3);
    check("st1_data",  64'(bus.stage_data),  64'h002233);
    check("st1_ready", 64'(bus.in_ready),    64'h0);
    tick();
    check("st2_valid", 64'(bus.stage_valid), 64'h3);
    check("st2_data",  64'(bus.stage_data),  64'h002233);
    check("st2_occ",   64'(bus.occupancy),   64'h2);
    bus.stall_req = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    tick();
    check("st3_data",  64'(bus.stage_data),  64'h223300);
    repeat (3) tick();

    // Flush stage 1 (and so stage 0) with a full pipe
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush_req = 3'b010;
    tick();
    bus.flush_req = '0;
    check("fl_valid", 64'(bus.stage_valid), 64'h4);
    check("fl_data",  64'(bus.stage_data),  64'h220000);
    check("fl_occ",   64'(bus.occupancy),   64'h1);
    repeat (2) tick();

    // Stall and flush together on stage 0: flush wins, input consumed
    send(8'h77, 1'b1);
    bus.stall_req = 3'b001;
    bus.flush_req = 3'b001;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h66;
    #1;
    check("sf_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.stall_req = '0;
    bus.flush_req = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    check("sf_valid", 64'(bus.stage_valid), 64'h2);
    check("sf_data",  64'(bus.stage_data),  64'h007700);
    check("sf_occ",   64'(bus.occupancy),   64'h1);
    repeat (3) tick();

    // Full freeze, then reset while frozen
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall_req = 3'b111;
    tick();
    check("fz_valid", 64'(bus.stage_valid), 64'h7);
    check("fz_data",  64'(bus.stage_data),  64'h112233);
    check("fz_ready", 64'(bus.in_ready),    64'h0);
    rst = 1'b0;
    tick();
    check("rs_valid", 64'(bus.stage_valid), 64'h0);
    check("rs_data",  64'(bus.stage_data),  64'h0);
    check("rs_occ",   64'(bus.occupancy),   64'h0);
    check("rs_out",   64'(bus.out_valid),   64'h0);
    rst           = 1'b1;
    bus.stall_req = '0;
    send(8'h99, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("rr_valid", 64'(bus.stage_valid), 64'h1);
    tick();
    tick();
    check("rr_out_v", 64'(bus.out_valid), 64'h1);
    check("rr_out_d", 64'(bus.out_data),  64'h99);
    repeat (3) tick();

    check("sb_empty", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_n.md
CTRL_PIPE_N -- requirements
Module: ctrl_pipe_n

Interface
REQ-001 SHALL have parameter W, default 45: control-bundle width in bits, 1..128.
REQ-002 SHALL have parameter STAGES, default 3: number of register stages, 2..8 (stage 0 youngest, STAGES-1 oldest).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: decode-side bundle present.
REQ-006 SHALL have port in_data, input, W bits: decode-side control bundle.
REQ-007 SHALL have port in_ready, output, 1 bit: stage 0 accepts this cycle.
REQ-008 SHALL have port stall_req, input, STAGES bits: bit i requests that stage i hold.
REQ-009 SHALL have port flush_req, input, STAGES bits: bit i requests that stage i be squashed.
REQ-010 SHALL have port stage_valid, output, STAGES bits: per-stage valid flag.
REQ-011 SHALL have port stage_data, output, STAGES*W bits: stage i occupies bits [i*W +: W].
REQ-012 SHALL have port out_valid / out_data, output, 1 / W bits: copies of stage STAGES-1.
REQ-013 SHALL have port occupancy, output, clog2(STAGES+1) bits: count of valid stages.

Function
REQ-014 Effective hold h[i] SHALL be the OR of stall_req[j] for j>=i; an older stall holds all younger stages.
REQ-015 Effective kill k[i] SHALL be the OR of flush_req[j] for j>=i; a flush squashes that stage and all younger stages.
REQ-016 Kill SHALL take priority over hold: if k[i], stage i valid becomes 0 and data becomes 0 next cycle.
REQ-017 Otherwise, if h[i], stage i SHALL keep valid and data unchanged.
REQ-018 Otherwise stage 0 SHALL load in_valid and in_data, with data zeroed when in_valid=0.
REQ-019 Otherwise stage i>0 SHALL load stage i-1 when h[i-1]=0, and SHALL load a bubble (valid 0, data 0) when h[i-1]=1.
REQ-020 Whenever a stage's valid is 0, its data SHALL be all-zero, so downstream control is inert.
REQ-021 in_ready SHALL equal ~h[0] (combinational); a bundle presented while k[0]=1 and in_ready=1 counts as consumed and is discarded.
REQ-022 With no stall or flush, a bundle accepted at edge t SHALL appear in stage i after edge t+i, and on out_* after edge t+STAGES-1.
REQ-023 occupancy SHALL be the registered popcount of stage_valid and SHALL be consistent with stage_valid in every cycle.
REQ-024 Simultaneous stall_req and flush_req on the same stage SHALL resolve as flush.
REQ-025 With all stall_req bits set, the pipe SHALL freeze; no bundle SHALL be lost or duplicated.
REQ-026 Outputs SHALL depend only on registers, except in_ready, which is combinational from stall_req.

Reset
REQ-027 When rst=0 at a clock edge, all stage_valid bits, all stage_data, out_*, and occupancy SHALL be 0 after that edge, regardless of stall or flush.
REQ-028 Reset asserted mid-stall SHALL discard all held bundles; the first edge with rst=1 SHALL resume normal operation from REQ-018.

Structure
REQ-029 Package ctrl_pipe_pkg SHALL hold the default W, the STAGES maximum, and the occupancy-width function.
REQ-030 One sub-module ctrl_pipe_stage SHALL be used: one valid+data register with kill, hold and load inputs, instantiated STAGES times by generate.
REQ-031 The h/k prefix-OR chains SHALL be combinational in the top module.

Verification
REQ-032 STAGES=3, W=8: stream 0x11, 0x22, 0x33 with no stall -> out_data 0x11/0x22/0x33 on consecutive cycles, out_valid=1 three cycles, occupancy peaks at 3.
REQ-033 Pipe full {0x33, 0x22, 0x11}, stall_req=3'b010 for 2 cycles -> stages 0 and 1 hold 0x33 and 0x22, stage 2 drains 0x11 then holds bubble (valid 0, data 0), in_ready=0 throughout.
REQ-034 Pipe full, flush_req=3'b010 for 1 cycle -> stages 0 and 1 become valid 0 with data 0, stage 2 advances normally, occupancy drops to 1.
REQ-035 stall_req=3'b001 and flush_req=3'b001 in the same cycle -> stage 0 becomes valid 0, and the presented bundle is discarded with in_ready=1.
REQ-036 rst=0 for one edge while stall_req=3'b111 and the pipe is full -> all valid 0, occupancy 0 next cycle; a bundle sent after release emerges after STAGES-1 edges.
